// File: rtl/lsync_pkg.sv
// lsync_pkg
//   Shared definitions for the long-sync datapath: default sample width and
//   window length (common with the long-sync correlator) and the width
//   derivation helpers used by the power/energy stages.
package lsync_pkg;

  localparam int LSYNC_IN_W = 6;
  localparam int LSYNC_WIN  = 16;

  // Ceiling log2, returns at least 1 so it can size a vector directly.
  function automatic int lsync_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // |I|^2+|Q|^2 peaks at 2^(2*in_w-1), which needs exactly 2*in_w bits.
  function automatic int lsync_mag_w(input int in_w);
    return 2 * in_w;
  endfunction

  // A sum of win magnitudes needs clog2(win+1) extra bits of headroom.
  function automatic int lsync_sum_w(input int in_w, input int win);
    return lsync_mag_w(in_w) + lsync_clog2(win + 1);
  endfunction

endpackage

// File: rtl/lsync_mag_sq_pipe.sv
// lsync_mag_sq_pipe
//   Two-stage pipelined magnitude-squared: I^2 and Q^2 are registered in the
//   cycle after in_strobe, their sum in the cycle after that.
// Ports:
//   CLK, a_RST_n     clock (rising edge), asynchronous active-low reset
//   clr              synchronous flush of the stage valids (data held)
//   in_strobe        I_in/Q_in valid
//   I_in, Q_in       signed samples, IN_W bits
//   mag_out          unsigned I^2+Q^2, 2*IN_W bits, held between strobes
//   mag_strobe       one-cycle pulse, 2 cycles after in_strobe
module lsync_mag_sq_pipe
  import lsync_pkg::*;
#(
  parameter int IN_W = LSYNC_IN_W
) (
  input  logic                   CLK,
  input  logic                   a_RST_n,
  input  logic                   clr,
  input  logic                   in_strobe,
  input  logic signed [IN_W-1:0] I_in,
  input  logic signed [IN_W-1:0] Q_in,
  output logic [2*IN_W-1:0]      mag_out,
  output logic                   mag_strobe
);

  localparam int SQ_W  = 2 * IN_W - 1;
  localparam int MAG_W = 2 * IN_W;

  // Square of a signed sample; the largest result, (-2^(IN_W-1))^2, still
  // fits in 2*IN_W-1 unsigned bits, so the top bit is dropped.
  function automatic logic [SQ_W-1:0] square_mag(input logic signed [IN_W-1:0] x);
    logic signed [2*IN_W-1:0] xe;
    logic signed [2*IN_W-1:0] p;
    xe = {{IN_W{x[IN_W-1]}}, x};
    p  = xe * xe;
    return p[SQ_W-1:0];
  endfunction

  logic [SQ_W-1:0]  i_sq_p1_q, i_sq_p1_d;
  logic [SQ_W-1:0]  q_sq_p1_q, q_sq_p1_d;
  logic             vld_p1_q, vld_p1_d;
  logic [MAG_W-1:0] mag_p2_q, mag_p2_d;
  logic             vld_p2_q, vld_p2_d;

  always_comb begin
    // Stage 1: squares; a sample arriving with clr is dropped.
    i_sq_p1_d = i_sq_p1_q;
    q_sq_p1_d = q_sq_p1_q;
    vld_p1_d  = in_strobe & ~clr;
    if (in_strobe && !clr) begin
      i_sq_p1_d = square_mag(I_in);
      q_sq_p1_d = square_mag(Q_in);
    end
    // Stage 2: sum; clr kills the in-flight sample but keeps mag_out.
    mag_p2_d = mag_p2_q;
    vld_p2_d = vld_p1_q & ~clr;
    if (vld_p1_q && !clr) begin
      mag_p2_d = {1'b0, i_sq_p1_q} + {1'b0, q_sq_p1_q};
    end
  end

  always_ff @(posedge CLK or negedge a_RST_n) begin
    if (!a_RST_n) begin
      i_sq_p1_q <= '0;
      q_sq_p1_q <= '0;
      vld_p1_q  <= 1'b0;
      mag_p2_q  <= '0;
      vld_p2_q  <= 1'b0;
    end else begin
      i_sq_p1_q <= i_sq_p1_d;
      q_sq_p1_q <= q_sq_p1_d;
      vld_p1_q  <= vld_p1_d;
      mag_p2_q  <= mag_p2_d;
      vld_p2_q  <= vld_p2_d;
    end
  end

  assign mag_out    = mag_p2_q;
  assign mag_strobe = vld_p2_q;

endmodule

// File: rtl/lsync_power_window.sv
// lsync_power_window
//   Per-sample power |I|^2+|Q|^2 plus a sliding-window energy over the last
//   WIN strobed samples. Idle cycles do not advance the window.
// Ports:
//   CLK, a_RST_n     clock (rising edge), asynchronous active-low reset
//   clr              synchronous clear: flush pipeline, restart window fill
//   in_strobe        I_in/Q_in valid
//   I_in, Q_in       signed samples, IN_W bits
//   mag_out          unsigned I^2+Q^2 (MAG_W), strobed by mag_strobe
//   energy_out       unsigned window sum (SUM_W), strobed by energy_strobe
//   win_full         level, WIN samples accumulated since reset/clr
module lsync_power_window
  import lsync_pkg::*;
#(
  parameter int IN_W  = LSYNC_IN_W,
  parameter int WIN   = LSYNC_WIN,
  parameter int MAG_W = lsync_mag_w(IN_W),
  parameter int SUM_W = lsync_sum_w(IN_W, WIN)
) (
  input  logic                   CLK,
  input  logic                   a_RST_n,
  input  logic                   clr,
  input  logic                   in_strobe,
  input  logic signed [IN_W-1:0] I_in,
  input  logic signed [IN_W-1:0] Q_in,
  output logic [MAG_W-1:0]       mag_out,
  output logic                   mag_strobe,
  output logic [SUM_W-1:0]       energy_out,
  output logic                   energy_strobe,
  output logic                   win_full
);

  localparam int PTR_W  = lsync_clog2(WIN);
  localparam int FILL_W = lsync_clog2(WIN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIN);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(WIN - 1);

  lsync_mag_sq_pipe #(
    .IN_W (IN_W)
  ) u_mag_sq_pipe (
    .CLK        (CLK),
    .a_RST_n    (a_RST_n),
    .clr        (clr),
    .in_strobe  (in_strobe),
    .I_in       (I_in),
    .Q_in       (Q_in),
    .mag_out    (mag_out),
    .mag_strobe (mag_strobe)
  );

  // Window history; contents are never cleared, the fill count decides
  // whether an entry is live.
  logic [MAG_W-1:0]  win_mem [WIN];

  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [SUM_W-1:0]  energy_q, energy_d;
  logic              en_stb_q, en_stb_d;
  logic [MAG_W-1:0]  old_mag;

  always_comb begin
    // Stage 3: slide the window. Until the window is full the slot being
    // overwritten holds stale data and must not be subtracted.
    old_mag  = (fill_q == FILL_FULL) ? win_mem[wr_ptr_q] : '0;
    acc_d    = acc_q;
    fill_d   = fill_q;
    wr_ptr_d = wr_ptr_q;
    energy_d = energy_q;
    en_stb_d = 1'b0;
    if (clr) begin
      acc_d    = '0;
      fill_d   = '0;
      wr_ptr_d = '0;
    end else if (mag_strobe) begin
      acc_d    = acc_q + SUM_W'(mag_out) - SUM_W'(old_mag);
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (fill_q != FILL_FULL) fill_d = fill_q + FILL_W'(1);
      if (fill_d == FILL_FULL) begin
        en_stb_d = 1'b1;
        energy_d = acc_d;
      end
    end
  end

  always_ff @(posedge CLK or negedge a_RST_n) begin
    if (!a_RST_n) begin
      acc_q    <= '0;
      fill_q   <= '0;
      wr_ptr_q <= '0;
      energy_q <= '0;
      en_stb_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      fill_q   <= fill_d;
      wr_ptr_q <= wr_ptr_d;
      energy_q <= energy_d;
      en_stb_q <= en_stb_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mag_strobe && !clr) win_mem[wr_ptr_q] <= mag_out;
  end

  assign energy_out    = energy_q;
  assign energy_strobe = en_stb_q;
  assign win_full      = (fill_q == FILL_FULL);

endmodule

// File: doc/lsync_power_window.md
Name: lsync_power_window

Overview:
- Parametrised successor to the long-sync magnitude-squared stage.
- Pipelined |I|²+|Q|² on each strobed I/Q sample, plus a sliding-window energy sum over the last WIN strobed samples.
- Sits between the long-sync input sample stream and the long-sync normaliser/peak detector.
- Provides per-sample power and windowed energy, each with its own strobe.

Parameters:
- IN_W, 6, signed width of I_in/Q_in.
- WIN, 16, window length in strobed samples (≥2, any integer).
- MAG_W, 2*IN_W, width of mag_out; derived, do not override.
- SUM_W, MAG_W+$clog2(WIN+1), width of energy_out; derived.

Ports:
- CLK  in  1  system clock, rising edge.
- a_RST_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: flush pipeline, restart window fill.
- in_strobe  in  1  I_in/Q_in valid this cycle.
- I_in  in  IN_W  signed in-phase sample.
- Q_in  in  IN_W  signed quadrature sample.
- mag_out  out  MAG_W  unsigned I²+Q².
- mag_strobe  out  1  one-cycle pulse, mag_out valid.
- energy_out  out  SUM_W  unsigned sum of last WIN mag values.
- energy_strobe  out  1  one-cycle pulse, energy_out valid (window full only).
- win_full  out  1  level: WIN samples accumulated since reset/clr.

Behaviour:
- Reset (a_RST_n=0, asynchronous): all outputs, pipeline registers, accumulator and fill counter go to 0 immediately. Buffer RAM contents are don't-care.
- Stage 1, cycle after in_strobe: register I², Q² (each 2*IN_W-1 bits unsigned) and a valid bit.
- Stage 2: mag_out <= I²+Q² and mag_strobe=1 for one cycle.
  - Latency from in_strobe to mag_strobe: 2 cycles.
  - Max value 2^(2*IN_W-1) (e.g. 2048 at IN_W=6), which fits MAG_W exactly, so no saturation is needed.
- Stage 3, on mag valid:
  - Write mag into a circular buffer of depth WIN at wr_ptr; wr_ptr wraps WIN-1→0.
  - The old entry at wr_ptr is read out as the subtrahend.
  - acc <= acc + mag − old, where old is forced to 0 while fill<WIN. Buffer is never explicitly cleared.
  - fill counter increments saturating at WIN. win_full = (fill==WIN).
  - energy_strobe=1 for one cycle when the update occurs with fill (after increment) == WIN; energy_out <= acc_next.
  - Latency from in_strobe to energy_strobe: 3 cycles.
- energy_out holds its last value between strobes. mag_out also holds between strobes.
- Non-contiguous strobes: idle cycles are not counted. The window spans strobed samples only. Back-to-back strobes are supported at full rate, with no stall.
- clr=1:
  - Next edge zeroes the stage valids, acc, fill, wr_ptr, win_full and both strobes.
  - In-flight samples are discarded.
  - mag_out/energy_out data values are held.
- clr and in_strobe in the same cycle: clr wins and the sample is dropped.
- Reset deasserted mid-stream: the first in_strobe afterwards is sample 0 of a fresh window.
- Arithmetic is unsigned from stage 1 onward. The accumulator never underflows, because each subtracted value was previously added.

Decomposition:
- Shared package lsync_pkg:
  - width helper functions (clog2, MAG_W/SUM_W derivation);
  - default IN_W/WIN constants shared with the long-sync correlator.
- Sub-module lsync_mag_sq_pipe (IN_W), covering stages 1–2:
  - inputs clr, in_strobe, I_in, Q_in;
  - outputs mag_out, mag_strobe.
- Top level holds the buffer, accumulator and fill counter.

Test Plan (IN_W=6, WIN=4 unless noted):
- Single strobe I=−32, Q=−32 → mag_out=2048, mag_strobe high exactly 2 cycles later for 1 cycle; no energy_strobe; win_full=0.
- Continuous I=3, Q=4:
  - mag 25 every cycle.
  - First energy_strobe on the 4th sample (3 cycles after its strobe), energy_out=100; win_full rises with it.
  - Stays 100 with a strobe every cycle thereafter.
- Continuous Q=0, I=1,2,3,4,5,6 → energy_out sequence 30, 54, 86, one per strobe.
- Same stream as the previous scenario with 0–3 random idle cycles between strobes → identical energy values. No strobes are asserted in gaps.
- After window full at 100, assert clr, then feed I=1, Q=0 ×4:
  - win_full=0 and no energy_strobe for the first 3 samples;
  - then energy_out=4;
  - old 25s are not subtracted.
- Drop a_RST_n mid-stream between clock edges → all outputs 0 before the next edge. After release, a fresh window is required before any energy_strobe, and the first energy equals the sum of 4 new samples.
